sheet_recorder: RTL and testbench

- Captures live key-hold vectors into a frame memory, one frame per tempo tick.
- Produces sheets in the same 63-bit-per-frame format the playback side consumes. It is the writer end of the sheet-frame interface.
- Sits between the keyboard scanner/debouncer and the playback path. The playback path reads recorded frames through a synchronous read port.

---
 rtl/sheet_recorder_pkg.sv | 21 ++
 rtl/sheet_recorder_if.sv | 26 ++
 rtl/sheet_frame_ram.sv | 29 ++
 rtl/sheet_recorder.sv | 122 ++++++++++++
 tb/tb_sheet_recorder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/sheet_recorder_pkg.sv
// rtl/sheet_recorder_pkg.sv - shared sheet-frame format, tempo, state and beat constants
package sheet_recorder_pkg;

  localparam int KEY_W       = 63;
  localparam int DEPTH       = 1296;
  localparam int ADDR_W      = 11;
  localparam int TICK_PERIOD = 8333332;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REC   = 2'd2,
    ST_DONE  = 2'd3
  } rec_state_t;

  localparam int BEAT_N = 6;
  localparam logic [0:BEAT_N-1][5:0] BEAT_PAT = '{
    6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001
  };

endpackage

// File: rtl/sheet_recorder_if.sv
// rtl/sheet_recorder_if.sv - control, live-key and playback-read signals of the recorder
interface sheet_recorder_if #(
  parameter int KEY_W  = sheet_recorder_pkg::KEY_W,
  parameter int ADDR_W = sheet_recorder_pkg::ADDR_W
);
  logic              rec_start;
  logic              rec_stop;
  logic [KEY_W-1:0]  keys_in;
  logic [ADDR_W-1:0] rd_addr;
  logic [KEY_W-1:0]  rd_data;
  // One extra bit so a completely full memory (DEPTH frames) is representable.
  logic [ADDR_W:0]   rec_len;
  logic              recording;
  logic              full;
  logic [5:0]        beat_display;

  modport master (
    output rec_start, rec_stop, keys_in, rd_addr,
    input  rd_data, rec_len, recording, full, beat_display
  );

  modport slave (
    input  rec_start, rec_stop, keys_in, rd_addr,
    output rd_data, rec_len, recording, full, beat_display
  );
endinterface

// File: rtl/sheet_frame_ram.sv
// rtl/sheet_frame_ram.sv - simple dual-port frame memory with registered read (read-old-data)
module sheet_frame_ram #(
  parameter int KEY_W  = 63,
  parameter int DEPTH  = 1296,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [KEY_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [KEY_W-1:0]  o_rdata
);
  logic [KEY_W-1:0] r_mem [DEPTH];
  logic [KEY_W-1:0] r_rdata;

  // Contents are deliberately left uninitialised so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rdata <= '0;
    else       r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sheet_recorder.sv
// rtl/sheet_recorder.sv - records debounced key-hold vectors into sheet frames, one per tempo tick
module sheet_recorder #(
  parameter int KEY_W       = sheet_recorder_pkg::KEY_W,
  parameter int DEPTH       = sheet_recorder_pkg::DEPTH,
  parameter int ADDR_W      = sheet_recorder_pkg::ADDR_W,
  parameter int TICK_PERIOD = sheet_recorder_pkg::TICK_PERIOD
) (
  input logic               clk_100mhz,
  input logic               rst,
  sheet_recorder_if.slave   bus
);
  import sheet_recorder_pkg::*;

  localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int LEN_W = ADDR_W + 1;

  rec_state_t       r_state;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [KEY_W-1:0] r_acc;
  logic [LEN_W-1:0] r_rec_len;
  logic             r_full;
  logic             r_recording;
  logic             r_phase;
  logic [2:0]       r_beat_idx;
  logic [5:0]       r_beat_display;

  logic             w_tick;
  logic             w_last;
  logic             w_arm;
  logic             w_we;
  logic [KEY_W-1:0] w_frame;

  assign w_tick  = (r_tick_cnt == CNT_W'(TICK_PERIOD - 1));
  assign w_last  = (r_rec_len == LEN_W'(DEPTH - 1));
  assign w_frame = r_acc | bus.keys_in;
  // A stop always beats a start, and beats a tick so the partial window is dropped.
  assign w_arm   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.rec_start && !bus.rec_stop;
  assign w_we    = (r_state == ST_REC) && w_tick && !bus.rec_stop;

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_tick_cnt     <= '0;
      r_acc          <= '0;
      r_rec_len      <= '0;
      r_full         <= 1'b0;
      r_recording    <= 1'b0;
      r_phase        <= 1'b0;
      r_beat_idx     <= '0;
      r_beat_display <= '0;
    end else if (w_arm) begin
      r_state        <= ST_ARMED;
      r_tick_cnt     <= '0;
      r_acc          <= '0;
      r_rec_len      <= '0;
      r_full         <= 1'b0;
      r_recording    <= 1'b1;
      r_phase        <= 1'b0;
      r_beat_idx     <= '0;
      r_beat_display <= '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (bus.rec_stop) begin
            r_state     <= ST_IDLE;
            r_recording <= 1'b0;
          end else if (bus.keys_in != '0) begin
            r_state    <= ST_REC;
            r_tick_cnt <= '0;
            r_acc      <= bus.keys_in;
          end
        end
        ST_REC: begin
          if (bus.rec_stop) begin
            r_state     <= ST_DONE;
            r_recording <= 1'b0;
          end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_acc      <= '0;
            r_rec_len  <= r_rec_len + LEN_W'(1);
            // Even frame indices light the next beat; odd ones advance the beat counter.
            if (!r_phase) begin
              r_beat_display <= BEAT_PAT[r_beat_idx];
              r_phase        <= 1'b1;
            end else begin
              r_phase    <= 1'b0;
              r_beat_idx <= (r_beat_idx == 3'd5) ? 3'd0 : r_beat_idx + 3'd1;
            end
            if (w_last) begin
              r_full      <= 1'b1;
              r_state     <= ST_DONE;
              r_recording <= 1'b0;
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            r_acc      <= w_frame;
          end
        end
        default: ;
      endcase
    end
  end

  sheet_frame_ram #(
    .KEY_W  (KEY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk_100mhz),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_waddr (r_rec_len[ADDR_W-1:0]),
    .i_wdata (w_frame),
    .i_raddr (bus.rd_addr),
    .o_rdata (bus.rd_data)
  );

  assign bus.rec_len      = r_rec_len;
  assign bus.recording    = r_recording;
  assign bus.full         = r_full;
  assign bus.beat_display = r_beat_display;
endmodule

// File: tb/tb_sheet_recorder.sv
// tb/tb_sheet_recorder.sv - directed self-checking bench for sheet_recorder
module tb_sheet_recorder;
  localparam int KEY_W = 63;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;
  localparam int TICK_PERIOD = 4;

  logic clk_100mhz;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [KEY_W-1:0] kv [DEPTH];

  sheet_recorder_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();

  sheet_recorder #(
    .KEY_W       (KEY_W),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TICK_PERIOD (TICK_PERIOD)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .bus        (bus)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic step(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.rec_start = 1'b0;
    bus.rec_stop = 1'b0;
    bus.keys_in = '0;
    bus.rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) kv[i] = 63'h1 << (i * 3);

    step(2);
    chk("rst_rec_len", 64'(bus.rec_len), 64'd0);
    chk("rst_recording", 64'(bus.recording), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_beat", 64'(bus.beat_display), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    rst = 1'b0;
    step(1);

    // Arm, then stay armed through ten idle cycles.
    bus.rec_start = 1'b1; step(1); bus.rec_start = 1'b0;
    chk("armed_recording", 64'(bus.recording), 64'd1);
    step(10);
    chk("armed_wait_recording", 64'(bus.recording), 64'd1);
    chk("armed_wait_len", 64'(bus.rec_len), 64'd0);

    bus.keys_in = 63'h1; step(1);
    step(3);
    chk("pre_tick_len", 64'(bus.rec_len), 64'd0);
    step(1);
    chk("first_tick_len", 64'(bus.rec_len), 64'd1);
    chk("first_tick_beat", 64'(bus.beat_display), 64'h20);

    // Frame 1: a one-cycle 0x4 press inside the window.
    step(1); bus.keys_in = 63'h4; step(1); bus.keys_in = 63'h1; step(2);
    chk("frame1_len", 64'(bus.rec_len), 64'd2);
    chk("frame1_beat", 64'(bus.beat_display), 64'h20);
    step(4);
    chk("frame2_len", 64'(bus.rec_len), 64'd3);
    chk("frame2_beat", 64'(bus.beat_display), 64'h10);

    bus.rd_addr = 3'd1; step(1);
    chk("rd_pulse_frame", 64'(bus.rd_data), 64'h5);
    bus.rd_addr = 3'd2; step(1);
    chk("rd_plain_frame", 64'(bus.rd_data), 64'h1);

    // Asynchronous reset in the middle of a window.
    rst = 1'b1; #1;
    chk("async_rst_len", 64'(bus.rec_len), 64'd0);
    chk("async_rst_recording", 64'(bus.recording), 64'd0);
    chk("async_rst_beat", 64'(bus.beat_display), 64'd0);
    chk("async_rst_rd_data", 64'(bus.rd_data), 64'd0);
    step(1); rst = 1'b0; bus.keys_in = '0; step(1);

    // Full recording with a distinct key vector per frame.
    bus.rec_start = 1'b1; step(1); bus.rec_start = 1'b0;
    chk("full_arm_recording", 64'(bus.recording), 64'd1);
    bus.keys_in = kv[0]; step(1); step(4);
    chk("full_f0_len", 64'(bus.rec_len), 64'd1);
    chk("full_f0_beat", 64'(bus.beat_display), 64'h20);
    for (int k = 1; k < DEPTH; k++) begin
      bus.keys_in = kv[k]; step(4);
      chk($sformatf("full_f%0d_len", k), 64'(bus.rec_len), 64'(k + 1));
      case (k)
        1: chk("full_f1_beat", 64'(bus.beat_display), 64'h20);
        2: chk("full_f2_beat", 64'(bus.beat_display), 64'h10);
        4: chk("full_f4_beat", 64'(bus.beat_display), 64'h08);
        6: chk("full_f6_beat", 64'(bus.beat_display), 64'h04);
        default: ;
      endcase
    end
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_recording", 64'(bus.recording), 64'd0);
    bus.keys_in = 63'h7; step(8);
    chk("full_hold_len", 64'(bus.rec_len), 64'd8);
    chk("full_hold_flag", 64'(bus.full), 64'd1);

    bus.rd_addr = 3'd0; step(1);
    chk("rd_addr0", 64'(bus.rd_data), 64'(kv[0]));
    bus.rd_addr = 3'd1; step(1);
    chk("rd_addr1", 64'(bus.rd_data), 64'(kv[1]));
    bus.rd_addr = 3'd2; step(1);
    chk("rd_addr2", 64'(bus.rd_data), 64'(kv[2]));
    bus.rd_addr = 3'd7; step(1);
    chk("rd_addr7", 64'(bus.rd_data), 64'(kv[7]));

    // Stop coinciding with the third tick.
    bus.keys_in = '0;
    bus.rec_start = 1'b1; step(1); bus.rec_start = 1'b0;
    chk("rearm_full_clear", 64'(bus.full), 64'd0);
    chk("rearm_len_clear", 64'(bus.rec_len), 64'd0);
    chk("rearm_beat_clear", 64'(bus.beat_display), 64'd0);
    bus.keys_in = 63'h1; step(1); step(4); step(4);
    chk("stop_pre_len", 64'(bus.rec_len), 64'd2);
    step(3);
    bus.rec_stop = 1'b1; step(1); bus.rec_stop = 1'b0;
    chk("stop_tick_len", 64'(bus.rec_len), 64'd2);
    chk("stop_tick_recording", 64'(bus.recording), 64'd0);
    chk("stop_tick_full", 64'(bus.full), 64'd0);
    bus.rd_addr = 3'd2; step(1);
    chk("stop_tick_no_write", 64'(bus.rd_data), 64'(kv[2]));
    step(8);
    chk("done_hold_len", 64'(bus.rec_len), 64'd2);

    bus.rec_start = 1'b1; bus.rec_stop = 1'b1; step(1);
    bus.rec_start = 1'b0; bus.rec_stop = 1'b0;
    chk("start_stop_done_recording", 64'(bus.recording), 64'd0);
    chk("start_stop_done_len", 64'(bus.rec_len), 64'd2);

    // Abort from ARMED returns to IDLE with an empty sheet.
    bus.keys_in = '0;
    bus.rec_start = 1'b1; step(1); bus.rec_start = 1'b0;
    bus.rec_stop = 1'b1; step(1); bus.rec_stop = 1'b0;
    chk("abort_recording", 64'(bus.recording), 64'd0);
    chk("abort_len", 64'(bus.rec_len), 64'd0);
    bus.keys_in = 63'h1; step(6);
    chk("abort_idle_len", 64'(bus.rec_len), 64'd0);
    chk("abort_idle_recording", 64'(bus.recording), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
